inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch stage directly downstream of the PC register.
- Accepts the current pc, issues one instruction-memory read over a req/gnt/rvalid handshake, and holds the returned word in an instruction register until the decoder takes it.
- Splits the word into the opcode, immd16 and immd26 fields consumed by the decoder and the next-pc logic.
- Supports a flush on redirect and flags misaligned pc.

Parameters:
- ADDR_W, 32, pc / instruction-memory address width
- RESET_INSTR, 32'h0000_0000, value held in instr while no valid instruction is present

Ports:
- clk  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- pc  in  ADDR_W  address to fetch
- pc_valid  in  1  pc is presented for fetch
- pc_ready  out  1  fetch accepts pc this cycle
- flush  in  1  discard the in-flight or held instruction (jump/branch redirect)
- imem_req  out  1  read request to instruction memory
- imem_addr  out  ADDR_W  read address; word-aligned
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- instr_valid  out  1  instr holds a valid instruction
- dec_ready  in  1  decoder consumes instr this cycle
- instr  out  32  instruction register
- instr_pc  out  ADDR_W  pc of the held instruction
- opcode  out  6  instr[31:26]
- immd16  out  16  instr[15:0]
- immd26  out  26  instr[25:0]
- misalign  out  1  held entry came from a pc with pc[1:0] != 0

Behaviour:
- Reset (RST=1 at a clock edge):
  - state goes to IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instr=RESET_INSTR, instr_pc=0, misalign=0.
  - Any outstanding memory response is forgotten.
  - RST has priority over every other input.
- States: IDLE, REQ, WAIT, FULL, DRAIN.
- pc_ready = !flush && (IDLE || (FULL && dec_ready)). Combinational, no RST term; its value during reset is don't-care.
- Fetch accept (pc_valid && pc_ready):
  - pc is registered into instr_pc.
  - If pc[1:0] == 0: imem_addr = pc and imem_req = 1 from the next cycle; state goes to REQ.
  - If pc[1:0] != 0: no memory request is issued. Next state is FULL with instr=RESET_INSTR, misalign=1, instr_valid=1.
- FULL && dec_ready without a new accept: go to IDLE, instr_valid=0.
- REQ:
  - imem_req stays high and imem_addr stays stable until imem_gnt.
  - On imem_gnt: imem_req drops the next cycle and state goes to WAIT.
- WAIT:
  - On imem_rvalid: instr = imem_rdata, misalign=0, instr_valid=1 next cycle; state goes to FULL.
  - imem_rvalid in any state other than WAIT/DRAIN is ignored.
- Latency: with gnt in the request cycle and rvalid one cycle later, instr_valid rises 3 cycles after pc is accepted.
- Field outputs (opcode, immd16, immd26) are pure slices of instr. They are meaningful only while instr_valid=1.
- Exactly one memory transaction is outstanding at any time.
- flush (checked before any normal transition):
  - IDLE: no effect.
  - REQ with imem_gnt in the same cycle: go to DRAIN. REQ without imem_gnt: go to IDLE. In both cases imem_req drops the next cycle.
  - WAIT with imem_rvalid in the same cycle: the data is discarded and state goes to IDLE. WAIT without imem_rvalid: go to DRAIN.
  - FULL: instr_valid=0 next cycle, go to IDLE. dec_ready in the same cycle is ignored; the decoder must not consume on a flush cycle.
  - DRAIN: stay in DRAIN.
- DRAIN: wait for imem_rvalid, discard the data, then go to IDLE. instr_valid stays 0 throughout.
- Holding FULL with dec_ready=0: instr, instr_pc and misalign are stable indefinitely.

Test Plan:
- Basic fetch: pc=32'h0000_0040, pc_valid, gnt in the request cycle, rvalid one cycle later with rdata=32'h2008_0005 -> imem_addr=32'h40; instr_valid 3 cycles after accept with instr_pc=32'h40, opcode=6'h08, immd16=16'h0005, immd26=26'h008_0005.
- Back-to-back: dec_ready=1 while FULL with pc_valid for pc=32'h44 in the same cycle -> pc_ready=1; next imem_req is at 32'h44 with no idle cycle; the first instruction is consumed exactly once.
- Backpressure: hold dec_ready=0 for 10 cycles while FULL -> instr_valid=1, instr unchanged, pc_ready=0, imem_req=0 throughout.
- Flush while WAIT, rvalid arriving 4 cycles later with rdata=32'hDEAD_BEEF -> state goes to DRAIN; instr_valid never rises and instr never takes 32'hDEAD_BEEF; pc_ready=1 the cycle after rvalid.
- Misaligned: pc=32'h0000_0042 -> no imem_req; next cycle instr_valid=1, misalign=1, instr=RESET_INSTR, instr_pc=32'h42.
- Reset mid-operation: RST=1 in REQ with gnt=0 -> next cycle imem_req=0, instr_valid=0, state IDLE; a later stray rvalid is ignored.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC register and the decoder.
// Ports: clk/RST (sync, active-high); pc/pc_valid/pc_ready fetch-request
//   handshake; flush redirect; imem_req/imem_addr/imem_gnt/imem_rvalid/
//   imem_rdata memory read port; instr_valid/dec_ready/instr/instr_pc to
//   the decoder; opcode/immd16/immd26 field slices; misalign flag.
module inst_fetch #(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode,
    output logic [15:0]       immd16,
    output logic [25:0]       immd26,
    output logic              misalign
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] FULL  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0] state;
    logic       accept;
    logic       aligned;

    // A new pc can enter while idle, or while the held word is being
    // consumed, so back-to-back fetches lose no cycle.
    assign pc_ready = !flush &&
                      ((state == IDLE) ||
                       ((state == FULL) && dec_ready));
    assign accept   = pc_valid && pc_ready;
    assign aligned  = (pc[1:0] == 2'b00);

    assign opcode = instr[31:26];
    assign immd16 = instr[15:0];
    assign immd26 = instr[25:0];

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= RESET_INSTR;
            instr_pc    <= '0;
            misalign    <= 1'b0;
        end else if (accept) begin
            // accept already implies no flush this cycle
            instr_pc <= pc;
            instr    <= RESET_INSTR;
            if (aligned) begin
                state       <= REQ;
                imem_req    <= 1'b1;
                imem_addr   <= pc;
                instr_valid <= 1'b0;
                misalign    <= 1'b0;
            end else begin
                // misaligned pc never reaches memory; the decoder
                // receives the reset word flagged as misaligned
                state       <= FULL;
                instr_valid <= 1'b1;
                misalign    <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                REQ: begin
                    if (flush) begin
                        imem_req <= 1'b0;
                        // a granted read still owes us a response
                        state    <= imem_gnt ? DRAIN : IDLE;
                    end else if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= imem_rvalid ? IDLE : DRAIN;
                    end else if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        misalign    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= FULL;
                    end
                end
                FULL: begin
                    // flush wins over a same-cycle consume
                    if (flush || dec_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= RESET_INSTR;
                        misalign    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DRAIN: begin
                    // a further flush changes nothing here; the owed
                    // response is still swallowed so the port goes idle
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    instr       <= RESET_INSTR;
                    misalign    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus a randomized run checked against
// a transaction-level model of the fetch slot and the memory responder.
module tb_inst_fetch;

    localparam int          AW = 32;
    localparam logic [31:0] RI = 32'hFC00_0000;

    logic          clk = 1'b0;
    logic          RST;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          pc_ready;
    logic          flush;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic          dec_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [5:0]    opcode;
    logic [15:0]   immd16;
    logic [25:0]   immd26;
    logic          misalign;

    int errors = 0;
    int checks = 0;

    inst_fetch #(.ADDR_W(AW), .RESET_INSTR(RI)) dut (
        .clk(clk), .RST(RST), .pc(pc), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .flush(flush), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .dec_ready(dec_ready),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
        .immd16(immd16), .immd26(immd26), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs;
        RST = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        RST = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== RI) begin errors++; $display("FAIL rst_instr got=%h want=%h", instr, RI); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h want=0", instr_pc); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b want=0", misalign); end
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL rst_pc_ready got=%b want=1", pc_ready); end
    endtask

    task automatic test_basic_fetch;
        pc = 32'h40; pc_valid = 1'b1; dec_ready = 1'b0;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL basic_pc_ready got=%b want=1", pc_ready); end
        @(negedge clk);
        pc_valid = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got=%b want=1", imem_req); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL basic_addr got=%h want=40", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got=%b want=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", instr_valid); end
        imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", instr_valid); end
        checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr got=%h want=20080005", instr); end
        checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL basic_instr_pc got=%h want=40", instr_pc); end
        checks++; if (opcode !== 6'h08) begin errors++; $display("FAIL basic_opcode got=%h want=08", opcode); end
        checks++; if (immd16 !== 16'h0005) begin errors++; $display("FAIL basic_immd16 got=%h want=0005", immd16); end
        checks++; if (immd26 !== 26'h008_0005) begin errors++; $display("FAIL basic_immd26 got=%h want=0080005", immd26); end
    endtask

    task automatic test_back_to_back;
        dec_ready = 1'b1; pc_valid = 1'b1; pc = 32'h44;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL b2b_pc_ready got=%b want=1", pc_ready); end
        @(negedge clk);
        dec_ready = 1'b0; pc_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_consume_once got=%b want=0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req got=%b want=1", imem_req); end
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL b2b_addr got=%h want=44", imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b want=1", instr_valid); end
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL b2b_instr got=%h want=12345678", instr); end
        checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL b2b_instr_pc got=%h want=44", instr_pc); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 10; i++) begin
            pc_valid = 1'b1; pc = 32'h80; dec_ready = 1'b0;
            #1;
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid i=%0d got=%b want=1", i, instr_valid); end
            checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL bp_instr i=%0d got=%h want=12345678", i, instr); end
            checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL bp_instr_pc i=%0d got=%h want=44", i, instr_pc); end
            checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_pc_ready i=%0d got=%b want=0", i, pc_ready); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req i=%0d got=%b want=0", i, imem_req); end
            @(negedge clk);
        end
        pc_valid = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b want=0", instr_valid); end
        checks++; if (instr !== RI) begin errors++; $display("FAIL bp_release_instr got=%h want=%h", instr, RI); end
    endtask

    task automatic test_flush_wait;
        pc = 32'h48; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_valid i=%0d got=%b want=0", i, instr_valid); end
            checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL fl_drain_ready i=%0d got=%b want=0", i, pc_ready); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fl_req i=%0d got=%b want=0", i, imem_req); end
            @(negedge clk);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL fl_rvalid_ready got=%b want=0", pc_ready); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL fl_after_ready got=%b want=1", pc_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_after_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== RI) begin errors++; $display("FAIL fl_discard got=%h want=%h", instr, RI); end
    endtask

    task automatic test_misaligned;
        pc = 32'h42; pc_valid = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL mis_pc_ready got=%b want=1", pc_ready); end
        @(negedge clk);
        pc_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req got=%b want=0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got=%b want=1", instr_valid); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got=%b want=1", misalign); end
        checks++; if (instr !== RI) begin errors++; $display("FAIL mis_instr got=%h want=%h", instr, RI); end
        checks++; if (instr_pc !== 32'h42) begin errors++; $display("FAIL mis_instr_pc got=%h want=42", instr_pc); end
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mis_consume got=%b want=0", instr_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b want=0", misalign); end
    endtask

    task automatic test_reset_mid;
        pc = 32'h50; pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b want=1", imem_req); end
        RST = 1'b1; imem_gnt = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_drop got=%b want=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", instr_valid); end
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%b want=1", pc_ready); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmid_stray_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== RI) begin errors++; $display("FAIL rmid_stray_instr got=%h want=%h", instr, RI); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_stray_req got=%b want=0", imem_req); end
    endtask

    // Model: one fetch slot (pc, data, arrived, granted) plus an owed
    // memory response that is either delivered or drained after a flush.
    task automatic test_random(input int n);
        bit          ev, emis, earr, egnt, drn, rp;
        logic [31:0] epc, edat, rdat;
        int          rc;
        bit          exp_valid, exp_req, exp_ready;
        bit          grant_now, deliver, consume, accept;
        ev = 0; emis = 0; earr = 0; egnt = 0; drn = 0; rp = 0;
        epc = '0; edat = RI; rdat = '0; rc = 0;
        idle_inputs();
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        for (int cyc = 0; cyc < n; cyc++) begin
            exp_valid = ev && earr;
            exp_req   = ev && !emis && !egnt;
            checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, instr_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (instr !== edat || instr_pc !== epc || misalign !== emis ||
                    opcode !== edat[31:26] || immd16 !== edat[15:0] ||
                    immd26 !== edat[25:0]) begin
                    errors++;
                    $display("FAIL rnd_entry cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc, instr, instr_pc, misalign, edat, epc, emis);
                end
            end else begin
                checks++; if (instr !== RI) begin errors++; $display("FAIL rnd_idle_instr cyc=%0d got=%h want=%h", cyc, instr, RI); end
            end
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== epc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, imem_addr, epc); end
            end

            RST       = ($urandom_range(0, 199) == 0);
            pc_valid  = ($urandom_range(0, 9) < 6);
            pc        = $urandom_range(0, 255) << 2;
            if ($urandom_range(0, 4) == 0) pc = pc | $urandom_range(1, 3);
            flush     = ($urandom_range(0, 9) == 0);
            dec_ready = 1'($urandom_range(0, 1));
            imem_gnt  = 1'($urandom_range(0, 1));
            deliver   = rp && (rc == 0);
            if (deliver) begin
                imem_rvalid = 1'b1; imem_rdata = rdat;
            end else if (!rp && $urandom_range(0, 9) == 0) begin
                imem_rvalid = 1'b1; imem_rdata = $urandom;
            end else begin
                imem_rvalid = 1'b0; imem_rdata = $urandom;
            end
            #1;
            exp_ready = !flush && !drn && (!ev || (exp_valid && dec_ready));
            if (!RST) begin
                checks++; if (pc_ready !== exp_ready) begin errors++; $display("FAIL rnd_pc_ready cyc=%0d got=%b want=%b", cyc, pc_ready, exp_ready); end
            end

            if (RST) begin
                ev = 0; drn = 0; rp = 0;
                edat = RI;
            end else begin
                grant_now = exp_req && imem_gnt;
                consume   = exp_valid && dec_ready && !flush;
                accept    = pc_valid && exp_ready;
                if (!flush && deliver) begin
                    if (drn) drn = 0;
                    else begin earr = 1; edat = rdat; end
                end
                if (deliver) rp = 0;
                else if (rp) rc--;
                if (grant_now) begin
                    rp = 1; rc = $urandom_range(0, 3);
                    rdat = mem_word(epc);
                end
                if (flush) begin
                    ev = 0;
                    drn = rp;
                end else begin
                    if (grant_now) egnt = 1;
                    if (consume) ev = 0;
                    if (accept) begin
                        ev = 1; epc = pc; emis = (pc[1:0] != 2'b00);
                        earr = emis; edat = RI; egnt = 0;
                    end
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_backpressure();
        test_flush_wait();
        test_misaligned();
        test_reset_mid();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
